atm_keypad_entry: RTL and testbench

//  Keypad front-end placed directly upstream of the ATM control FSM. Turns single-cycle key strobes into
//  the values the FSM consumes: a 4-bit account number, a 4-bit PIN and a 6-bit transaction amount.

---
 rtl/atm_keypad_entry.sv | 205 ++++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry
//   Keypad front-end for the ATM control FSM. Turns single-cycle key strobes into
//   an account digit, a PIN digit and a 6-bit amount. Each value is published with
//   a one-cycle valid pulse. Session aborts (card removal, CANCEL, inactivity) are
//   reported on o_abort, and rejected amounts on o_entry_err.
//
//   Handshake: i_key_valid is a one-cycle strobe and i_key_code is sampled in the
//   same cycle. Every output is registered, so each pulse appears in the cycle after
//   the key that caused it. The block has no back-pressure.
//
//   Optional feature macro: ENTRY_TIMEOUT_EN. When it is defined, an inactivity
//   counter aborts the session after TIMEOUT_CYCLES quiet cycles in ACC/PIN/AMT.
//   TIMEOUT_CYCLES exists only in that build. Without the macro, no counter is built.
//   o_dbg_state exposes the FSM state for debug and checkers.
module atm_keypad_entry #(
`ifdef ENTRY_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 1000,
`endif
   parameter int MAX_AMOUNT = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_card_in,
   input  logic       i_key_valid,
   input  logic [3:0] i_key_code,
   input  logic       i_amt_req,
   output logic [3:0] o_acc_number,
   output logic [3:0] o_pin,
   output logic       o_cred_valid,
   output logic [5:0] o_amount,
   output logic       o_amt_valid,
   output logic       o_entry_err,
   output logic       o_abort,
   output logic       o_busy,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACC  = 3'd1,
      S_PIN  = 3'd2,
      S_WAIT = 3'd3,
      S_AMT  = 3'd4
   } state_t;

   localparam logic [6:0] MAX_AMT7 = 7'(MAX_AMOUNT);

   state_t     r_state;
   logic [6:0] r_buf;
   logic [1:0] r_cnt;
   logic [3:0] r_acc_digit;
   logic [3:0] r_acc_number;
   logic [3:0] r_pin;
   logic [5:0] r_amount;
   logic       r_cred_valid;
   logic       r_amt_valid;
   logic       r_entry_err;
   logic       r_abort;
   logic       r_busy;

   logic       w_digit;
   logic       w_enter;
   logic       w_clear;
   logic       w_cancel;
   logic       w_entry;
   logic       w_tmo_hit;
   logic [6:0] w_buf_next;

   assign w_digit    = i_key_valid && (i_key_code <= 4'd9);
   assign w_enter    = i_key_valid && (i_key_code == 4'hA);
   assign w_clear    = i_key_valid && (i_key_code == 4'hB);
   assign w_cancel   = i_key_valid && (i_key_code == 4'hC);
   assign w_entry    = (r_state == S_ACC) || (r_state == S_PIN) || (r_state == S_AMT);
   // At most two digits are accumulated, so the result never exceeds 99.
   assign w_buf_next = 7'(r_buf * 7'd10) + {3'b000, i_key_code};

`ifdef ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;

   // Inactivity counter: it runs only in the entry states and restarts on any key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_tmo <= '0;
      else if (!w_entry || i_key_valid)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + 1'b1;
   end

   // A timeout outranks a key that arrives in the same cycle.
   assign w_tmo_hit = w_entry && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   // Main FSM: the state and all registered outputs are updated together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_buf        <= '0;
         r_cnt        <= '0;
         r_acc_digit  <= '0;
         r_acc_number <= '0;
         r_pin        <= '0;
         r_amount     <= '0;
         r_cred_valid <= 1'b0;
         r_amt_valid  <= 1'b0;
         r_entry_err  <= 1'b0;
         r_abort      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_cred_valid <= 1'b0;
         r_amt_valid  <= 1'b0;
         r_entry_err  <= 1'b0;
         r_abort      <= 1'b0;
         if (r_state == S_IDLE) begin
            if (i_card_in) begin
               r_state <= S_ACC;
               r_busy  <= 1'b1;
               r_buf   <= '0;
               r_cnt   <= '0;
            end
         end else if (!i_card_in || w_cancel || w_tmo_hit) begin
            // One abort pulse for the event, whichever cause has priority.
            r_abort      <= 1'b1;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_acc_digit  <= '0;
            r_acc_number <= '0;
            r_pin        <= '0;
            r_amount     <= '0;
         end else begin
            case (r_state)
               S_ACC, S_PIN: begin
                  if (w_digit) begin
                     r_buf <= {3'b000, i_key_code};
                     r_cnt <= 2'd1;
                  end else if (w_clear) begin
                     r_buf <= '0;
                     r_cnt <= '0;
                  end else if (w_enter && (r_cnt != 2'd0)) begin
                     r_buf <= '0;
                     r_cnt <= '0;
                     if (r_state == S_ACC) begin
                        r_acc_digit <= r_buf[3:0];
                        r_state     <= S_PIN;
                     end else begin
                        r_acc_number <= r_acc_digit;
                        r_pin        <= r_buf[3:0];
                        r_cred_valid <= 1'b1;
                        r_state      <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (i_amt_req) begin
                     r_state <= S_AMT;
                     r_buf   <= '0;
                     r_cnt   <= '0;
                  end
               end
               S_AMT: begin
                  if (w_digit) begin
                     if (r_cnt < 2'd2) begin
                        r_buf <= w_buf_next;
                        r_cnt <= r_cnt + 2'd1;
                     end
                  end else if (w_clear) begin
                     r_buf <= '0;
                     r_cnt <= '0;
                  end else if (w_enter) begin
                     r_buf <= '0;
                     r_cnt <= '0;
                     if ((r_cnt == 2'd0) || (r_buf > MAX_AMT7)) begin
                        r_entry_err <= 1'b1;
                     end else begin
                        r_amount    <= r_buf[5:0];
                        r_amt_valid <= 1'b1;
                        r_state     <= S_WAIT;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_acc_number = r_acc_number;
   assign o_pin        = r_pin;
   assign o_cred_valid = r_cred_valid;
   assign o_amount     = r_amount;
   assign o_amt_valid  = r_amt_valid;
   assign o_entry_err  = r_entry_err;
   assign o_abort      = r_abort;
   assign o_busy       = r_busy;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Testbench for atm_keypad_entry. It uses directed scenarios followed by random
// key traffic, checked every cycle against a digit-queue reference model.
module tb_atm_keypad_entry;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_card_in;
   logic       i_key_valid;
   logic [3:0] i_key_code;
   logic       i_amt_req;
   logic [3:0] o_acc_number;
   logic [3:0] o_pin;
   logic       o_cred_valid;
   logic [5:0] o_amount;
   logic       o_amt_valid;
   logic       o_entry_err;
   logic       o_abort;
   logic       o_busy;
   logic [2:0] o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the session phase, plus the digits entered for the current field.
   localparam int P_IDLE = 0, P_ACC = 1, P_PIN = 2, P_WAIT = 3, P_AMT = 4;
`ifdef ENTRY_TIMEOUT_EN
   localparam int TMO = 8;
`endif
   int m_ph;
   int m_digits[$];
   int m_acc_digit;
   int m_quiet;
   int e_acc, e_pin, e_amount, e_cred, e_amtv, e_err, e_abort, e_busy;

   // clock / reset block
   always #5 clk = ~clk;

   atm_keypad_entry #(
`ifdef ENTRY_TIMEOUT_EN
      .TIMEOUT_CYCLES(TMO),
`endif
      .MAX_AMOUNT(63)
   ) dut (
      .clk(clk), .rst(rst), .i_card_in(i_card_in), .i_key_valid(i_key_valid),
      .i_key_code(i_key_code), .i_amt_req(i_amt_req), .o_acc_number(o_acc_number),
      .o_pin(o_pin), .o_cred_valid(o_cred_valid), .o_amount(o_amount),
      .o_amt_valid(o_amt_valid), .o_entry_err(o_entry_err), .o_abort(o_abort),
      .o_busy(o_busy), .o_dbg_state(o_dbg_state)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("acc_number", int'(o_acc_number), e_acc);
      check_eq("pin",        int'(o_pin),        e_pin);
      check_eq("amount",     int'(o_amount),     e_amount);
      check_eq("cred_valid", int'(o_cred_valid), e_cred);
      check_eq("amt_valid",  int'(o_amt_valid),  e_amtv);
      check_eq("entry_err",  int'(o_entry_err),  e_err);
      check_eq("abort",      int'(o_abort),      e_abort);
      check_eq("busy",       int'(o_busy),       e_busy);
   endtask

   task automatic model_reset();
      m_ph = P_IDLE; m_digits.delete(); m_acc_digit = 0; m_quiet = 0;
      e_acc = 0; e_pin = 0; e_amount = 0;
      e_cred = 0; e_amtv = 0; e_err = 0; e_abort = 0; e_busy = 0;
   endtask

   // One clock of the model, computed from the session rules.
   task automatic model_step(input bit card, input bit kv, input int code, input bit areq);
      bit entry, dig, enter, clr, cancel, tmo;
      int val;
      e_cred = 0; e_amtv = 0; e_err = 0; e_abort = 0;
      entry  = (m_ph == P_ACC) || (m_ph == P_PIN) || (m_ph == P_AMT);
      dig    = kv && (code <= 9);
      enter  = kv && (code == 10);
      clr    = kv && (code == 11);
      cancel = kv && (code == 12);
      tmo    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmo = entry && (m_quiet == TMO - 1);
`endif
      if (m_ph == P_IDLE) begin
         if (card) begin m_ph = P_ACC; m_digits.delete(); m_quiet = 0; end
      end else if (!card || cancel || tmo) begin
         e_abort = 1; m_ph = P_IDLE; m_digits.delete();
         e_acc = 0; e_pin = 0; e_amount = 0; m_acc_digit = 0;
      end else begin
         if (entry) begin
            if (kv) m_quiet = 0; else m_quiet++;
         end
         case (m_ph)
            P_ACC, P_PIN: begin
               if (dig) begin m_digits.delete(); m_digits.push_back(code); end
               else if (clr) m_digits.delete();
               else if (enter && m_digits.size() > 0) begin
                  if (m_ph == P_ACC) begin
                     m_acc_digit = m_digits[0]; m_ph = P_PIN;
                  end else begin
                     e_acc = m_acc_digit; e_pin = m_digits[0]; e_cred = 1; m_ph = P_WAIT;
                  end
                  m_digits.delete();
               end
            end
            P_WAIT: if (areq) begin m_ph = P_AMT; m_digits.delete(); m_quiet = 0; end
            P_AMT: begin
               if (dig) begin
                  if (m_digits.size() < 2) m_digits.push_back(code);
               end else if (clr) m_digits.delete();
               else if (enter) begin
                  val = 0;
                  foreach (m_digits[i]) val = val * 10 + m_digits[i];
                  if (m_digits.size() == 0 || val > 63) e_err = 1;
                  else begin e_amount = val; e_amtv = 1; m_ph = P_WAIT; end
                  m_digits.delete();
               end
            end
            default: ;
         endcase
      end
      e_busy = (m_ph != P_IDLE) ? 1 : 0;
   endtask

   // driver: apply inputs at negedge, clock once, then check at the following negedge
   task automatic cycle(input bit card, input bit kv, input logic [3:0] code, input bit areq);
      i_card_in = card; i_key_valid = kv; i_key_code = code; i_amt_req = areq;
      model_step(card, kv, int'(code), areq);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic key(input logic [3:0] code);
      cycle(1'b1, 1'b1, code, 1'b0);
   endtask

   task automatic quiet();
      cycle(1'b1, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      int r;
      bit c_card, c_kv, c_areq;
      logic [3:0] c_code;
      rst = 1'b1; i_card_in = 1'b0; i_key_valid = 1'b0; i_key_code = 4'h0; i_amt_req = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      check_outputs();

      // Scenario 1: enter the account digit and the PIN.
      quiet();
      key(4'd2); key(4'hA); key(4'd1); key(4'hA);
      check_eq("t1_cred", int'(o_cred_valid), 1);
      check_eq("t1_acc",  int'(o_acc_number), 2);
      check_eq("t1_pin",  int'(o_pin), 1);
      quiet();
      check_eq("t1_cred_drop", int'(o_cred_valid), 0);

      // Scenario 2: enter amounts, including the boundary cases.
      cycle(1'b1, 1'b0, 4'h0, 1'b1);
      key(4'd4); key(4'd5); key(4'hA);
      check_eq("t2_amtv", int'(o_amt_valid), 1);
      check_eq("t2_amt45", int'(o_amount), 45);
      cycle(1'b1, 1'b0, 4'h0, 1'b1);
      key(4'd7); key(4'd0); key(4'hA);
      check_eq("t2_err70", int'(o_entry_err), 1);
      check_eq("t2_busy", int'(o_busy), 1);
      key(4'hA);
      check_eq("t2_err_empty", int'(o_entry_err), 1);
      key(4'd6); key(4'd3); key(4'hA);
      check_eq("t2_amt63", int'(o_amount), 63);
      cycle(1'b1, 1'b0, 4'h0, 1'b1);
      key(4'd6); key(4'd4); key(4'hA);
      check_eq("t2_err64", int'(o_entry_err), 1);
      key(4'd1); key(4'd2); key(4'd3); key(4'hA);
      check_eq("t2_amt12", int'(o_amount), 12);
      key(4'hC);
      check_eq("t2_cancel_abort", int'(o_abort), 1);
      check_eq("t2_cancel_amt", int'(o_amount), 0);

      // Scenario 3: an ENTER on an empty field is ignored; then move to PIN.
      quiet();
      key(4'd3); key(4'hB); key(4'hA);
      key(4'd1); key(4'hA);

      // Scenario 4: card removed and CANCEL in the same cycle give one abort.
      cycle(1'b0, 1'b1, 4'hC, 1'b0);
      check_eq("t4_abort", int'(o_abort), 1);
      check_eq("t4_busy", int'(o_busy), 0);
      cycle(1'b0, 1'b0, 4'h0, 1'b0);
      check_eq("t4_single_abort", int'(o_abort), 0);

      // Scenario 5: inactivity in ACC.
      quiet();
`ifdef ENTRY_TIMEOUT_EN
      for (int i = 0; i < TMO - 1; i++) quiet();
      check_eq("t5_no_early_abort", int'(o_abort), 0);
      quiet();
      check_eq("t5_tmo_abort", int'(o_abort), 1);
      check_eq("t5_tmo_busy", int'(o_busy), 0);
`else
      for (int i = 0; i < 20; i++) quiet();
      check_eq("t5_no_tmo_busy", int'(o_busy), 1);
`endif
      cycle(1'b0, 1'b0, 4'h0, 1'b0);

      // Scenario 6: asynchronous reset asserted during amount entry.
      quiet();
      key(4'd1); key(4'hA); key(4'd2); key(4'hA);
      cycle(1'b1, 1'b0, 4'h0, 1'b1);
      key(4'd4);
      i_key_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b0, 4'h0, 1'b0);
      check_eq("t6_no_abort", int'(o_abort), 0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         c_card = ($urandom_range(0, 99) < 98);
         c_kv   = ($urandom_range(0, 99) < 45);
         c_areq = ($urandom_range(0, 99) < 30);
         r = $urandom_range(0, 99);
         if (r < 60)      c_code = 4'($urandom_range(0, 9));
         else if (r < 85) c_code = 4'hA;
         else if (r < 93) c_code = 4'hB;
         else if (r < 97) c_code = 4'hC;
         else             c_code = 4'($urandom_range(13, 15));
         cycle(c_card, c_kv, c_code, c_areq);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
